// File: rtl/if_id_if.sv
// Fetch-side and decode-side signals of the IF/ID pipeline register.
// The stage takes the slave modport; the fetch unit and decode side take the master modport.
interface if_id_if #(
   parameter int CNT_W = 16
) ();
   logic [31:0]      inst_i;
   logic [31:0]      pc_i;
   logic             fetch_valid_i;
   logic             fetch_ready_o;
   logic             stallHold_i;
   logic             flush_i;
   logic [31:0]      inst_o;
   logic [31:0]      pc_o;
   logic             valid_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport slave (
      input  inst_i, pc_i, fetch_valid_i, stallHold_i, flush_i,
      output fetch_ready_o, inst_o, pc_o, valid_o, stall_cnt_o, flush_cnt_o
   );

   modport master (
      output inst_i, pc_i, fetch_valid_i, stallHold_i, flush_i,
      input  fetch_ready_o, inst_o, pc_o, valid_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, flush squashing and
// saturating stall/flush event counters.
module if_id_stage #(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic    clk_i,
   input  logic    rst_i,
   if_id_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0]      r_inst_reg, r_inst_next;
   logic [31:0]      r_pc_reg,   r_pc_next;
   logic             r_valid_reg, r_valid_next;
   logic [31:0]      s_inst_reg, s_inst_next;
   logic [31:0]      s_pc_reg,   s_pc_next;
   logic             s_valid_reg, s_valid_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
   logic             accept;

   // Ready depends only on the skid slot, so there is no input-to-ready path.
   assign bus.fetch_ready_o = !s_valid_reg;
   assign accept            = bus.fetch_valid_i && !s_valid_reg;

   always_comb begin
      r_inst_next    = r_inst_reg;
      r_pc_next      = r_pc_reg;
      r_valid_next   = r_valid_reg;
      s_inst_next    = s_inst_reg;
      s_pc_next      = s_pc_reg;
      s_valid_next   = s_valid_reg;
      stall_cnt_next = stall_cnt_reg;
      flush_cnt_next = flush_cnt_reg;

      if (bus.flush_i) begin
         // Wrong-path contents and the word presented this cycle are all dropped.
         r_inst_next  = NOP_INST;
         r_pc_next    = '0;
         r_valid_next = 1'b0;
         s_inst_next  = NOP_INST;
         s_pc_next    = '0;
         s_valid_next = 1'b0;
         if (flush_cnt_reg != CNT_MAX)
            flush_cnt_next = flush_cnt_reg + 1'b1;
      end else if (bus.stallHold_i) begin
         if (accept) begin
            s_inst_next  = bus.inst_i;
            s_pc_next    = bus.pc_i;
            s_valid_next = 1'b1;
         end
         if (r_valid_reg && (stall_cnt_reg != CNT_MAX))
            stall_cnt_next = stall_cnt_reg + 1'b1;
      end else if (s_valid_reg) begin
         // Drain the parked word first to keep program order.
         r_inst_next  = s_inst_reg;
         r_pc_next    = s_pc_reg;
         r_valid_next = 1'b1;
         s_inst_next  = accept ? bus.inst_i : NOP_INST;
         s_pc_next    = accept ? bus.pc_i   : '0;
         s_valid_next = accept;
      end else begin
         r_inst_next  = accept ? bus.inst_i : NOP_INST;
         r_pc_next    = accept ? bus.pc_i   : '0;
         r_valid_next = accept;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_inst_reg    <= NOP_INST;
         r_pc_reg      <= '0;
         r_valid_reg   <= 1'b0;
         s_inst_reg    <= NOP_INST;
         s_pc_reg      <= '0;
         s_valid_reg   <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         r_inst_reg    <= r_inst_next;
         r_pc_reg      <= r_pc_next;
         r_valid_reg   <= r_valid_next;
         s_inst_reg    <= s_inst_next;
         s_pc_reg      <= s_pc_next;
         s_valid_reg   <= s_valid_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   assign bus.inst_o      = r_inst_reg;
   assign bus.pc_o        = r_pc_reg;
   assign bus.valid_o     = r_valid_reg;
   assign bus.stall_cnt_o = stall_cnt_reg;
   assign bus.flush_cnt_o = flush_cnt_reg;
endmodule
